// File: rtl/lsu_unit.sv
// Load/store unit for the RV32I core.
// The ALU result is used as the effective address. The unit drives a
// request/acknowledge data bus with byte enables and formats load data.
// It stalls the core until the access acks, is rejected, or times out.
module lsu_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lsu_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic        lsu_err,
   output logic [31:0] load_data
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       load_data_q, load_data_d;
   // byte offset and funct3 of the in-flight access, needed to pick the load lane
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;

   logic              start;
   logic              illegal;
   logic              misaligned;
   logic [3:0]        be_req;
   logic [31:0]       wdata_req;
   logic [31:0]       lane;
   logic [31:0]       ld_fmt;
   logic [CNT_W-1:0]  cnt_inc;

   // Decode the incoming request: legality, alignment, byte lanes and store data.
   always_comb begin
      start      = (state_q == S_IDLE) && lsu_valid && (mem_read || mem_write);
      illegal    = 1'b0;
      misaligned = 1'b0;
      be_req     = 4'b1111;
      wdata_req  = store_data;
      if (mem_read && mem_write) begin
         illegal = 1'b1;
      end else if (mem_read) begin
         illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end else begin
         illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
      end
      case (funct3[1:0])
         2'b00: begin
            be_req    = 4'b0001 << addr[1:0];
            wdata_req = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_req     = 4'b0011 << addr[1:0];
            wdata_req  = {2{store_data[15:0]}};
            misaligned = addr[0];
         end
         default: begin
            be_req     = 4'b1111;
            wdata_req  = store_data;
            misaligned = (addr[1:0] != 2'b00);
         end
      endcase
   end

   // Select the addressed lane of the read word and sign/zero extend it.
   always_comb begin
      lane = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ld_fmt = {24'd0, lane[7:0]};
         3'b101:  ld_fmt = {16'd0, lane[15:0]};
         default: ld_fmt = lane;
      endcase
   end

   // Next-state and next-output logic for the IDLE/REQ/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      load_data_d = load_data_q;
      off_d       = off_q;
      f3_d        = f3_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cnt_inc     = cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (illegal || misaligned) begin
                  // rejected before any bus activity
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d     = S_REQ;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = mem_write;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = wdata_req;
                  mem_be_d    = be_req;
                  off_d       = addr[1:0];
                  f3_d        = funct3;
               end
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               // an ack on the final allowed cycle still completes cleanly
               state_d   = S_DONE;
               mem_req_d = 1'b0;
               done_d    = 1'b1;
               if (!mem_we_q) load_data_d = ld_fmt;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TMO) begin
                  state_d   = S_DONE;
                  mem_req_d = 1'b0;
                  done_d    = 1'b1;
                  err_d     = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         load_data_q <= '0;
         off_q       <= '0;
         f3_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         done_q      <= done_d;
         err_q       <= err_d;
         load_data_q <= load_data_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign lsu_done  = done_q;
   assign lsu_err   = err_q;
   assign load_data = load_data_q;
   // drops in DONE so the core retires that cycle with load_data valid
   assign lsu_stall = start || (state_q == S_REQ);

endmodule

// File: tb/tb_lsu_unit.sv
// Randomised scoreboard bench for lsu_unit with a behavioural reference model.
module tb_lsu_unit;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_valid, mem_read, mem_write, mem_ack;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data, mem_rdata;
   logic        mem_req, mem_we, lsu_stall, lsu_done, lsu_err;
   logic [31:0] mem_addr, mem_wdata, load_data;
   logic [3:0]  mem_be;

   lsu_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .lsu_stall(lsu_stall),
      .lsu_done(lsu_done), .lsu_err(lsu_err), .load_data(load_data)
   );

   always #5 clk = ~clk;

   typedef struct { bit err; logic [31:0] ld; } resp_t;
   typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; int cyc; } bus_t;

   resp_t       resp_q[$];
   bus_t        bus_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] model_ld;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      if (rd && wr) return 1'b0;
      if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
      if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b0;
      sz = 1 << f3[1:0];
      return (int'(a[1:0]) % sz) == 0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int sz, v;
      sz = 1 << f3[1:0];
      v  = ((1 << sz) - 1) << int'(a[1:0]);
      return v[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      int sz;
      logic [31:0] w;
      sz = 1 << f3[1:0];
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      int sz;
      longint v, lim;
      sz  = 1 << f3[1:0];
      lim = longint'(1) << (8 * sz);
      v   = longint'(rd >> (8 * int'(a[1:0]))) % lim;
      if (!f3[2] && sz < 4 && v >= lim / 2) v = v - lim;
      return v[31:0];
   endfunction

   // ---------------- stimulus ----------------
   task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdata, input int ack_at, input int rst_at);
      bit    legal, acked;
      int    cyc;
      resp_t r;
      bus_t  b;
      @(negedge clk);
      #1;
      legal = ref_legal(rd, wr, f3, a);
      acked = legal && ack_at >= 1 && ack_at <= TIMEOUT;
      cyc   = (rst_at > 0) ? rst_at : (acked ? ack_at : TIMEOUT);
      if (legal) begin
         b.we = wr; b.addr = {a[31:2], 2'b00}; b.be = ref_be(f3, a);
         b.wdata = wr ? ref_wdata(f3, sd) : 32'd0; b.cyc = cyc;
         bus_q.push_back(b);
      end
      if (rst_at == 0) begin
         if (acked && rd) model_ld = ref_load(f3, a, rdata);
         r.err = !acked;
         r.ld  = model_ld;
         resp_q.push_back(r);
      end
      lsu_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
      addr = a; store_data = sd; mem_rdata = rdata;
      #1 chk("stall_on_start", lsu_stall, 1'b1);
      @(negedge clk);
      lsu_valid = 1'b0;
      if (legal) begin
         for (int k = 1; k <= cyc; k++) begin
            lsu_valid = 1'($urandom_range(0, 1));
            if (rst_at == k) rst = 1'b1;
            mem_ack = (k == ack_at) && (rst_at == 0);
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
      lsu_valid = 1'b0;
      if (rst_at > 0) begin
         rst = 1'b0;
         model_ld = 32'd0;
         chk("rst_mem_req", mem_req, 1'b0);
         chk("rst_load_data", load_data, 32'd0);
         chk("rst_done", lsu_done, 1'b0);
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
         chk("late_ack_done", lsu_done, 1'b0);
         chk("late_ack_req", mem_req, 1'b0);
         @(negedge clk);
         chk("late_ack_done2", lsu_done, 1'b0);
      end
   endtask

   // ---------------- monitors ----------------
   resp_t mr;
   always @(negedge clk) begin
      if (lsu_done) begin
         if (resp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: lsu_done=1, expected 0");
         end else begin
            mr = resp_q.pop_front();
            chk("lsu_err", lsu_err, mr.err);
            chk("load_data", load_data, mr.ld);
            chk("stall_in_done", lsu_stall, 1'b0);
         end
      end else if (lsu_err) begin
         n_chk++; n_fail++;
         $display("FAIL err_without_done: lsu_err=1, expected 0");
      end
   end

   bus_t cur;
   bit   in_txn = 1'b0;
   int   req_cnt;
   always @(negedge clk) begin
      if (mem_req && !in_txn) begin
         if (bus_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_req: mem_req=1 addr=0x%0h, expected 0", mem_addr);
            cur = '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata, cyc: 0};
         end else begin
            cur = bus_q.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
            chk("mem_we", mem_we, cur.we);
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            else cur.wdata = mem_wdata;
         end
         in_txn  = 1'b1;
         req_cnt = 1;
      end else if (mem_req && in_txn) begin
         req_cnt++;
         chk("hold_addr", mem_addr, cur.addr);
         chk("hold_be_we_wdata", {mem_be, mem_we, mem_wdata}, {cur.be, cur.we, cur.wdata});
      end else if (!mem_req && in_txn) begin
         in_txn = 1'b0;
         chk("req_cycles", req_cnt, cur.cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [2:0] legal_f3 [5];
      logic [2:0] f3r;
      bit rd, wr;
      int sel;
      legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      rst = 1'b1; lsu_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
      funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; mem_rdata = 32'd0;
      model_ld = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {mem_req, mem_we, lsu_done, lsu_err, mem_be}, 8'd0);
      chk("reset_addr", mem_addr, 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      chk("reset_load_data", load_data, 32'd0);
      rst = 1'b0;

      do_op(0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'd0, 3, 0);          // SW, 3 req cycles
      do_op(1, 0, 3'b000, 32'h0000_2003, 32'd0, 32'h8000_0000, 1, 0);           // LB
      do_op(1, 0, 3'b100, 32'h0000_2003, 32'd0, 32'h8000_0000, 2, 0);           // LBU
      do_op(1, 0, 3'b010, 32'h0000_4000, 32'd0, 32'h1111_2222, 0, 2);           // reset in REQ 2
      do_op(0, 1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'd0, 1, 0);           // SH
      do_op(1, 0, 3'b001, 32'h0000_3001, 32'd0, 32'd0, 1, 0);                   // LH misaligned
      do_op(1, 0, 3'b010, 32'h0000_5000, 32'd0, 32'h1234_5678, 2, 0);           // LW
      do_op(1, 0, 3'b010, 32'h0000_5004, 32'd0, 32'hFFFF_FFFF, 0, 0);           // LW timeout
      do_op(1, 0, 3'b010, 32'h0000_5008, 32'd0, 32'hCAFE_F00D, TIMEOUT, 0);     // ack on last cycle
      do_op(1, 1, 3'b010, 32'h0000_6000, 32'd0, 32'd0, 1, 0);                   // read+write
      do_op(1, 0, 3'b011, 32'h0000_6000, 32'd0, 32'd0, 1, 0);                   // illegal load f3
      do_op(0, 1, 3'b100, 32'h0000_6000, 32'd0, 32'd0, 1, 0);                   // illegal store f3
      do_op(1, 0, 3'b101, 32'h0000_6002, 32'd0, 32'hFEDC_1234, 1, 0);           // LHU
      do_op(1, 0, 3'b001, 32'h0000_6002, 32'd0, 32'hFEDC_1234, 1, 0);           // LH
      do_op(0, 1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 32'd0, 4, 0);           // SB

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         rd  = (sel <= 5);
         wr  = (sel == 0) || (sel >= 6);
         if ($urandom_range(0, 3) != 0) f3r = legal_f3[$urandom_range(0, 4)];
         else f3r = 3'($urandom_range(0, 7));
         do_op(rd, wr, f3r, $urandom, $urandom, $urandom,
               ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2), 0);
      end

      repeat (4) @(negedge clk);
      chk("resp_queue_drained", resp_q.size(), 32'd0);
      chk("bus_queue_drained", bus_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
